// File: rtl/uart_baud_pkg.sv
// uart_baud_pkg: shared widths, types and constants for the baud generator.
// Fractional divisor support is enabled by defining UART_BAUD_FRAC_EN.
package uart_baud_pkg;

  localparam int CNT_W    = 16;
  localparam int FRAC_W   = 4;
  localparam int OS_SHIFT = 4;

  typedef logic [CNT_W-1:0]  div_int_t;
  typedef logic [FRAC_W-1:0] div_frac_t;

  localparam div_int_t DEFAULT_DIV = div_int_t'(347);
  localparam div_int_t MIN_DIV     = div_int_t'(2 << OS_SHIFT);

  // cycles per oversample slot for a given bit divisor
  function automatic div_int_t os_period(input div_int_t d);
    return d >> OS_SHIFT;
  endfunction

endpackage

// File: rtl/uart_baud_if.sv
// uart_baud_if: control inputs and strobe outputs of the baud generator.
// master = register file / shifter side, slave = generator.
interface uart_baud_if;
  import uart_baud_pkg::*;

  logic      bps_en;
  logic      sync_restart;
  logic      div_load;
  div_int_t  div_int;
  div_frac_t div_frac;
  logic      bit_tick;
  logic      mid_tick;
  logic      os_tick;
  logic      div_err;

  modport master (
    output bps_en,
    output sync_restart,
    output div_load,
    output div_int,
    output div_frac,
    input  bit_tick,
    input  mid_tick,
    input  os_tick,
    input  div_err
  );

  modport slave (
    input  bps_en,
    input  sync_restart,
    input  div_load,
    input  div_int,
    input  div_frac,
    output bit_tick,
    output mid_tick,
    output os_tick,
    output div_err
  );

endinterface

// File: rtl/uart_baud_gen_frac_acc.sv
// baud_frac_acc: fractional phase accumulator; carry stretches next bit.
// Only instantiated when UART_BAUD_FRAC_EN is defined.
module baud_frac_acc
  import uart_baud_pkg::*;
(
  input  logic      clk,
  input  logic      rst_i,
  input  logic      clr_i,
  input  logic      step_i,
  input  div_frac_t frac_i,
  output logic      carry_o
);

  div_frac_t acc_q;
  div_frac_t acc_d;
  logic      carry_q;
  logic      carry_d;

  // accumulate once per completed bit; clear on disable or realign
  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    if (clr_i) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (step_i) begin
      {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_i};
    end
  end

  // accumulator and carry registers
  always_ff @(posedge clk) begin
    if (rst_i) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign carry_o = carry_q;

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable bit/centre/oversample strobe generator.
// Define UART_BAUD_FRAC_EN to build the fractional divisor accumulator.
module uart_baud_gen
  import uart_baud_pkg::*;
(
  input  logic        clk,
  input  logic        RST,
  uart_baud_if.slave  bus
);

  localparam logic [CNT_W:0] P_ONE = 1;
  localparam div_int_t       D_ONE = 1;

  div_int_t cnt_q;
  div_int_t cnt_d;
  div_int_t os_cnt_q;
  div_int_t os_cnt_d;
  div_int_t act_int_q;
  div_int_t act_int_d;
  div_int_t pend_int_q;
  div_int_t pend_int_d;
  logic     pend_q;
  logic     pend_d;

  logic bit_q;
  logic bit_d;
  logic mid_q;
  logic mid_d;
  logic os_q;
  logic os_d;
  logic err_q;
  logic err_d;

  logic           carry;
  logic [CNT_W:0] period;
  div_int_t       os_per;
  logic           load_ok;
  logic           load_bad;
  logic           bit_end;
  logic           os_end;

  assign load_ok  = bus.div_load && (bus.div_int >= MIN_DIV);
  assign load_bad = bus.div_load && (bus.div_int <  MIN_DIV);
  assign period   = {1'b0, act_int_q} + {{CNT_W{1'b0}}, carry};
  assign bit_end  = ({1'b0, cnt_q} == (period - P_ONE));
  assign os_per   = os_period(act_int_q);
  assign os_end   = (os_cnt_q == (os_per - D_ONE));

`ifdef UART_BAUD_FRAC_EN
  div_frac_t act_frac_q;
  div_frac_t act_frac_d;
  div_frac_t pend_frac_q;
  div_frac_t pend_frac_d;
  logic      frac_clr;
  logic      frac_step;

  assign frac_clr  = !bus.bps_en || bus.sync_restart;
  assign frac_step = bus.bps_en && !bus.sync_restart && bit_end;

  baud_frac_acc u_frac (
    .clk     (clk),
    .rst_i   (RST),
    .clr_i   (frac_clr),
    .step_i  (frac_step),
    .frac_i  (act_frac_q),
    .carry_o (carry)
  );

  // fractional part follows the integer divisor through load/pend/apply
  always_comb begin
    act_frac_d  = act_frac_q;
    pend_frac_d = pend_frac_q;
    if (!bus.bps_en) begin
      if (load_ok) begin
        act_frac_d = bus.div_frac;
      end else if (pend_q) begin
        act_frac_d = pend_frac_q;
      end
    end else begin
      if ((bus.sync_restart || bit_end) && pend_q) begin
        act_frac_d = pend_frac_q;
      end
      if (load_ok) begin
        pend_frac_d = bus.div_frac;
      end
    end
  end

  // fractional divisor registers
  always_ff @(posedge clk) begin
    if (RST) begin
      act_frac_q  <= '0;
      pend_frac_q <= '0;
    end else begin
      act_frac_q  <= act_frac_d;
      pend_frac_q <= pend_frac_d;
    end
  end
`else
  logic unused_frac;

  assign carry       = 1'b0;
  assign unused_frac = ^bus.div_frac;
`endif

  // counters, divisor hand-over and strobe decode
  always_comb begin
    cnt_d      = cnt_q + D_ONE;
    os_cnt_d   = os_end ? '0 : os_cnt_q + D_ONE;
    act_int_d  = act_int_q;
    pend_d     = pend_q;
    pend_int_d = pend_int_q;
    bit_d      = 1'b0;
    mid_d      = 1'b0;
    os_d       = 1'b0;
    err_d      = load_bad;
    if (!bus.bps_en) begin
      cnt_d    = '0;
      os_cnt_d = '0;
      pend_d   = 1'b0;
      if (load_ok) begin
        act_int_d = bus.div_int;
      end else if (pend_q) begin
        act_int_d = pend_int_q;
      end
    end else begin
      mid_d = (cnt_q == (act_int_q >> 1));
      os_d  = os_end;
      bit_d = bit_end && !bus.sync_restart;
      if (bus.sync_restart || bit_end) begin
        cnt_d    = '0;
        os_cnt_d = '0;
        if (pend_q) begin
          act_int_d = pend_int_q;
          pend_d    = 1'b0;
        end
      end
      if (load_ok) begin
        pend_d     = 1'b1;
        pend_int_d = bus.div_int;
      end
    end
  end

  // state and registered strobes
  always_ff @(posedge clk) begin
    if (RST) begin
      cnt_q      <= '0;
      os_cnt_q   <= '0;
      act_int_q  <= DEFAULT_DIV;
      pend_q     <= 1'b0;
      pend_int_q <= '0;
      bit_q      <= 1'b0;
      mid_q      <= 1'b0;
      os_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      os_cnt_q   <= os_cnt_d;
      act_int_q  <= act_int_d;
      pend_q     <= pend_d;
      pend_int_q <= pend_int_d;
      bit_q      <= bit_d;
      mid_q      <= mid_d;
      os_q       <= os_d;
      err_q      <= err_d;
    end
  end

  assign bus.bit_tick = bit_q;
  assign bus.mid_tick = mid_q;
  assign bus.os_tick  = os_q;
  assign bus.div_err  = err_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed table, corner sequences and randomized
// run against a period/phase reference model.
module tb_uart_baud_gen;

  logic clk = 1'b0;
  logic RST;

  uart_baud_if bus ();

  uart_baud_gen dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    int div;
    bit ld;
    bit err;
    int bitp;
    int mid;
    int os;
  } vec_t;

  vec_t tbl [8];

  int m_pos, m_act, m_actf, m_pi, m_pf, m_acc, m_extra;
  bit m_hp;
  int e_exp;

  task automatic chk(input string nm, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int outs();
    return int'({bus.bit_tick, bus.mid_tick, bus.os_tick, bus.div_err});
  endfunction

  task automatic do_reset();
    RST              = 1'b1;
    bus.bps_en       = 1'b0;
    bus.sync_restart = 1'b0;
    bus.div_load     = 1'b0;
    bus.div_int      = '0;
    bus.div_frac     = '0;
    tick();
    tick();
    RST = 1'b0;
    chk("reset_outs", outs(), 0);
  endtask

  task automatic load(input int di, input int df);
    bus.div_int  = 16'(di);
    bus.div_frac = 4'(df);
    bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
  endtask

  task automatic wait_bit(output int k, output int mk, output int on);
    k  = 0;
    mk = 0;
    on = 0;
    for (int i = 1; i <= 3000; i++) begin
      tick();
      if (bus.mid_tick && mk == 0) mk = i;
      if (bus.os_tick) on++;
      if (bus.bit_tick) begin
        k = i;
        break;
      end
    end
  endtask

  function automatic int frac_of(input int df);
`ifdef UART_BAUD_FRAC_EN
    return df;
`else
    return 0 * df;
`endif
  endfunction

  task automatic model_reset();
    m_pos = 0; m_act = 347; m_actf = 0;
    m_hp = 0; m_pi = 0; m_pf = 0;
    m_acc = 0; m_extra = 0;
  endtask

  // expected outputs after the coming edge, from bit position arithmetic
  task automatic model_step(input bit rst, input bit en, input bit rs,
                            input bit ld, input int di, input int df);
    int per, osp;
    bit ok, wrap, eb, em, eo, ee;
    ok = ld && di >= 32;
    eb = 0; em = 0; eo = 0;
    ee = ld && !ok;
    if (rst) begin
      ee = 0;
      model_reset();
    end else if (!en) begin
      m_pos = 0; m_acc = 0; m_extra = 0;
      if (ok) begin
        m_act = di; m_actf = frac_of(df);
      end else if (m_hp) begin
        m_act = m_pi; m_actf = m_pf;
      end
      m_hp = 0;
    end else begin
      per  = m_act + m_extra;
      osp  = m_act / 16;
      em   = (m_pos == m_act / 2);
      eo   = ((m_pos % osp) == osp - 1);
      wrap = (m_pos == per - 1);
      eb   = wrap && !rs;
      if (rs) begin
        m_acc = 0; m_extra = 0;
      end else if (wrap) begin
        m_acc   = m_acc + m_actf;
        m_extra = (m_acc >= 16) ? 1 : 0;
        m_acc   = m_acc % 16;
      end
      if (rs || wrap) begin
        m_pos = 0;
        if (m_hp) begin
          m_act = m_pi; m_actf = m_pf; m_hp = 0;
        end
      end else begin
        m_pos++;
      end
      if (ok) begin
        m_hp = 1; m_pi = di; m_pf = frac_of(df);
      end
    end
    e_exp = int'({eb, em, eo, ee});
  endtask

  initial begin
    int k, mk, on, tot;
    bit en, rs, ld, rr;
    int di, df;

    tbl[0] = '{347,  1'b0, 1'b0, 347,  174, 16};
    tbl[1] = '{100,  1'b1, 1'b0, 100,  51,  16};
    tbl[2] = '{20,   1'b1, 1'b1, 347,  174, 16};
    tbl[3] = '{32,   1'b1, 1'b0, 32,   17,  16};
    tbl[4] = '{31,   1'b1, 1'b1, 347,  174, 16};
    tbl[5] = '{33,   1'b1, 1'b0, 33,   17,  16};
    tbl[6] = '{1000, 1'b1, 1'b0, 1000, 501, 16};
    tbl[7] = '{0,    1'b1, 1'b1, 347,  174, 16};

    for (int i = 0; i < 8; i++) begin
      do_reset();
      if (tbl[i].ld) begin
        load(tbl[i].div, 0);
        chk($sformatf("tbl%0d_err", i), int'(bus.div_err), int'(tbl[i].err));
        tick();
        chk($sformatf("tbl%0d_err_clr", i), int'(bus.div_err), 0);
      end
      bus.bps_en = 1'b1;
      wait_bit(k, mk, on);
      chk($sformatf("tbl%0d_bit", i), k, tbl[i].bitp);
      chk($sformatf("tbl%0d_mid", i), mk, tbl[i].mid);
      chk($sformatf("tbl%0d_os", i), on, tbl[i].os);
      wait_bit(k, mk, on);
      chk($sformatf("tbl%0d_bit2", i), k, tbl[i].bitp);
    end

    // load while running takes effect at the next bit boundary
    do_reset();
    bus.bps_en = 1'b1;
    repeat (50) tick();
    load(100, 0);
    wait_bit(k, mk, on);
    chk("run_load_first", 51 + k, 347);
    wait_bit(k, mk, on);
    chk("run_load_second", k, 100);
    chk("run_load_mid", mk, 51);
    wait_bit(k, mk, on);
    chk("run_load_third", k, 100);

    // rejected load while running
    do_reset();
    bus.bps_en = 1'b1;
    repeat (10) tick();
    load(20, 0);
    chk("run_bad_err", int'(bus.div_err), 1);
    tick();
    chk("run_bad_err_clr", int'(bus.div_err), 0);
    wait_bit(k, mk, on);
    chk("run_bad_period", 12 + k, 347);

    // phase restart mid-bit
    do_reset();
    bus.bps_en = 1'b1;
    repeat (200) tick();
    bus.sync_restart = 1'b1;
    tick();
    bus.sync_restart = 1'b0;
    chk("restart_no_bit", int'(bus.bit_tick), 0);
    wait_bit(k, mk, on);
    chk("restart_bit", k, 347);
    chk("restart_mid", mk, 174);
    chk("restart_os", on, 16);

    // reset mid-bit with a pending load, right where mid_tick would fire
    do_reset();
    bus.bps_en = 1'b1;
    repeat (30) tick();
    load(100, 0);
    repeat (173 - 31) tick();
    RST = 1'b1;
    tick();
    chk("rst_mid_outs", outs(), 0);
    RST = 1'b0;
    wait_bit(k, mk, on);
    chk("rst_period", k, 347);
    chk("rst_mid", mk, 174);

`ifdef UART_BAUD_FRAC_EN
    do_reset();
    load(100, 8);
    bus.bps_en = 1'b1;
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      wait_bit(k, mk, on);
      tot += k;
      chk($sformatf("frac_bit%0d", i), k,
          (i >= 2 && (i % 2) == 0) ? 101 : 100);
    end
    chk("frac_total", tot, 1607);
`endif

    // randomized run against the reference model
    do_reset();
    model_reset();
    en = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      rr = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 399) == 0) en = !en;
      rs = ($urandom_range(0, 249) == 0);
      ld = ($urandom_range(0, 149) == 0);
      di = int'($urandom_range(16, 130));
      df = int'($urandom_range(0, 15));
      RST              = rr;
      bus.bps_en       = en;
      bus.sync_restart = rs;
      bus.div_load     = ld;
      bus.div_int      = 16'(di);
      bus.div_frac     = 4'(df);
      model_step(rr, en, rs, ld, di, df);
      tick();
      chk($sformatf("rand_c%0d", c), outs(), e_exp);
    end
    RST          = 1'b0;
    bus.div_load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
